// File: rtl/dice_pkg.sv
// Shared definitions for the dice display: scan states and 7-segment patterns.
package dice_pkg;

    // Display scan sequence: dead time, ones digit, dead time, tens digit.
    typedef enum logic [1:0] {
        DEAD_B = 2'd0,
        SHOW1  = 2'd1,
        DEAD_A = 2'd2,
        SHOW10 = 2'd3
    } scan_state_e;

    // Active-true segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp never lit.
    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-true 7-segment pattern; codes 10-15 decode to blank.
module seg7_decode
    import dice_pkg::*;
(
    input  logic [3:0] value,
    output logic [7:0] pattern
);

    // Pure lookup; anything outside 0-9 is shown dark.
    always_comb begin
        pattern = SEG_BLANK;
        case (value)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Two-digit multiplexed 7-segment scanner with dead time between digits,
// once-per-frame digit latching and run-time segment/common polarity straps.
// Pins are registered and reflect the scan state one cycle later.
module seven_seg_scan_ctrl
    import dice_pkg::*;
#(
    parameter int SLOT_CYCLES = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       blank_lz,
    input  logic       display_en,
    input  logic       seg_act_hi,
    input  logic       com_act_hi,
    output logic [7:0] seg_out,
    output logic       com1,
    output logic       com10,
    output logic [1:0] com_oe,
    output logic       frame_tick
);

    localparam int CNT_MAX = (SLOT_CYCLES > DEAD_CYCLES) ? SLOT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       shadow1_q, shadow1_d;
    logic [3:0]       shadow10_q, shadow10_d;
    logic [7:0]       seg_q, seg_d;
    logic             com1_q, com1_d;
    logic             com10_q, com10_d;
    logic             tick_q, tick_d;

    logic [7:0] pat1, pat10;
    logic [7:0] pat_sel;
    logic       com1_on, com10_on;

    seg7_decode u_dec_ones (.value(shadow1_q),  .pattern(pat1));
    seg7_decode u_dec_tens (.value(shadow10_q), .pattern(pat10));

    // Scan sequencing: dwell counter, state advance and the frame-start digit latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        shadow1_d  = shadow1_q;
        shadow10_d = shadow10_q;
        tick_d     = 1'b0;
        if (!display_en) begin
            state_d = DEAD_B;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DEAD_B: if (cnt_q == DEAD_LAST) begin
                    state_d    = SHOW1;
                    cnt_d      = '0;
                    shadow1_d  = digit1;
                    shadow10_d = digit10;
                    tick_d     = 1'b1;
                end
                SHOW1: if (cnt_q == SLOT_LAST) begin
                    state_d = DEAD_A;
                    cnt_d   = '0;
                end
                DEAD_A: if (cnt_q == DEAD_LAST) begin
                    state_d = SHOW10;
                    cnt_d   = '0;
                end
                SHOW10: if (cnt_q == SLOT_LAST) begin
                    state_d = DEAD_B;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = DEAD_B;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pin values: only one SHOW state can be current, so commons stay exclusive;
    // display_en gates immediately so disabling darkens on the very next edge.
    always_comb begin
        pat_sel  = SEG_BLANK;
        com1_on  = 1'b0;
        com10_on = 1'b0;
        if (display_en) begin
            if (state_q == SHOW1) begin
                com1_on = 1'b1;
                pat_sel = pat1;
            end else if (state_q == SHOW10) begin
                com10_on = 1'b1;
                pat_sel  = (blank_lz && shadow10_q == 4'd0) ? SEG_BLANK : pat10;
            end
        end
        seg_d   = seg_act_hi ? pat_sel : ~pat_sel;
        com1_d  = com_act_hi ? com1_on : ~com1_on;
        com10_d = com_act_hi ? com10_on : ~com10_on;
    end

    // State, shadow and output registers; reset drives everything to its off level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DEAD_B;
            cnt_q      <= '0;
            shadow1_q  <= 4'd15;
            shadow10_q <= 4'd15;
            seg_q      <= {8{~seg_act_hi}};
            com1_q     <= ~com_act_hi;
            com10_q    <= ~com_act_hi;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow1_q  <= shadow1_d;
            shadow10_q <= shadow10_d;
            seg_q      <= seg_d;
            com1_q     <= com1_d;
            com10_q    <= com10_d;
            tick_q     <= tick_d;
        end
    end

    assign seg_out    = seg_q;
    assign com1       = com1_q;
    assign com10      = com10_q;
    assign com_oe     = 2'b11;
    assign frame_tick = tick_q;

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexes the single shared segment bus between the two common-cathode/anode digits (ones, tens) of the dice display.
- Sequences commons with dead-time to prevent ghosting, latches digit values once per frame to prevent tearing, and applies the run-time segment and common polarity straps.
- Sits between the dice roller (digit1/digit10 sources) and the uo_out/uio_out[1:0] pads.

Parameters:
- SLOT_CYCLES, 1000: clock cycles a digit is lit per slot (>=2).
- DEAD_CYCLES, 16: clock cycles with both commons inactive between slots (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- digit1  in  4  ones value, BCD 0-9; 15 means blank; 10-14 are undefined and are shown blank.
- digit10  in  4  tens value, same encoding as digit1.
- blank_lz  in  1  1 blanks the tens digit when digit10==0.
- display_en  in  1  0 forces display dark.
- seg_act_hi  in  1  segment polarity strap; 1 = segment lit when driven high.
- com_act_hi  in  1  common polarity strap; 1 = digit enabled when common is high.
- seg_out  out  8  segment bus {dp,g,f,e,d,c,b,a}; dp is always off.
- com1  out  1  ones common.
- com10  out  1  tens common.
- com_oe  out  2  output enables for {com10,com1}.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Registered outputs: all outputs are registered, with 1-cycle latency from state/strap to pin.
- Off level:
  - A segment or common is "off" when it is driven to ~act level for its strap.
  - Strap changes take effect on the next clock edge, mid-frame included.
- Reset values:
  - state=DEAD_B, slot counter=0, latched digits=15.
  - seg_out={8{~seg_act_hi}}, com1=com10=~com_act_hi, com_oe=2'b11, frame_tick=0.
- State machine (counter cnt):
  - DEAD_B: both commons off, segments off. After DEAD_CYCLES cycles go to SHOW1. On the same edge latch digit1/digit10 into shadow registers and pulse frame_tick.
  - SHOW1: com1 active, seg_out=decode(shadow1). After SLOT_CYCLES go to DEAD_A.
  - DEAD_A: all off. After DEAD_CYCLES go to SHOW10.
  - SHOW10: com10 active, seg_out=decode(shadow10), or off if blank_lz and shadow10==0. After SLOT_CYCLES go to DEAD_B.
- Frame length: 2*(SLOT_CYCLES+DEAD_CYCLES) cycles.
- Exclusivity: the two commons are never active in the same cycle, including across strap changes.
- Decode patterns (active-true, before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10-15 = 00 (blank).
- Polarity application: seg_out = seg_act_hi ? pat : ~pat.
- display_en:
  - Low: on the next edge go to DEAD_B with cnt=0, all off. Stay there with no frame_tick while low.
  - Rising edge: the normal DEAD_B dwell runs, then SHOW1.
- Digit input changes mid-frame are not visible until the next frame latch.
- Reset mid-frame: reset-value outputs appear on the next edge regardless of state.
- Counter: sized clog2(max(SLOT_CYCLES,DEAD_CYCLES)); it wraps to 0 on every state transition and never overflows.

Decomposition:
- Shared package dice_pkg holds:
  - scan state enum {DEAD_B, SHOW1, DEAD_A, SHOW10};
  - SEG_BLANK=8'h00;
  - the 7-seg pattern constants.
- One sub-module, seg7_decode: 4-bit value to 8-bit active-true pattern, purely combinational, reused by the tens and ones paths.

Test Plan (SLOT_CYCLES=4, DEAD_CYCLES=2, seg_act_hi=1, com_act_hi=0):
- Reset: hold rst 3 cycles -> seg_out=00, com1=com10=1, com_oe=3. First frame_tick 2 cycles after release, then seg_out=06 with com1=0 for 4 cycles when digit1=1.
- digit10=4, digit1=2, blank_lz=0 -> per 12-cycle frame:
  - 4 cycles com1=0, seg_out=5B;
  - 2 cycles all off;
  - 4 cycles com10=0, seg_out=66;
  - 2 cycles all off.
  - Commons are never both 0.
- digit10=0, digit1=7, blank_lz=1 -> the SHOW10 slot has seg_out=00 with com10 active; the SHOW1 slot shows 07. With blank_lz=0 the SHOW10 slot shows 3F.
- Flip seg_act_hi to 0 and com_act_hi to 1 mid-SHOW1 with digit1=8 -> next cycle seg_out=80, com1=1, com10=0. Dead slots show seg_out=FF, commons 0.
- Change digit1 3->9 during SHOW10 -> the current frame is unaffected; the next SHOW1 shows 6F.
- display_en low in SHOW1 -> next cycle all off and no frame_tick for 20 cycles. After re-enable, the first SHOW1 starts exactly 2 cycles later. A digit value of 12 is shown as 00.
